// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined integer ALU.
//   ALU_FUNC_W  width of the function code carried on aluFunc_in
//   alu_func_e  encoding of the supported operations; codes above
//               ALU_SRA are legal on the bus and evaluate to zero.
package alu_pkg;

    localparam int ALU_FUNC_W = 4;

    typedef enum logic [ALU_FUNC_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_func_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational evaluation of one ALU operation.
// Ports:
//   a, b    in   XLEN        operands
//   func    in   ALU_FUNC_W  operation code (alu_func_e); unknown codes give 0
//   result  out  XLEN        operation result
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]       a,
    input  logic [XLEN-1:0]       b,
    input  logic [ALU_FUNC_W-1:0] func,
    output logic [XLEN-1:0]       result
);

    localparam int SHAMT_W = $clog2(XLEN);

    // Shift amount is the low log2(XLEN) bits of b; upper bits are ignored.
    logic [SHAMT_W-1:0] shamt;
    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        result = '0;
        case (func)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU functional unit for the execute stage.
// The result is computed once at the input; PIPE_STAGES register stages then
// carry {valid, tag, result} to the output with valid/ready flow control,
// bubble collapse, and a flush that kills every in-flight op.
// Ports:
//   clk_in         in   1      clock, rising edge
//   rst_n_in       in   1      asynchronous active-low reset
//   flush_in       in   1      drop all in-flight ops (and any op accepted now)
//   in_valid_in    in   1      op present
//   in_ready_out   out  1      op can be accepted this cycle
//   rval1_in       in   XLEN   operand A
//   rval2_in       in   XLEN   operand B
//   aluFunc_in     in   4      operation code
//   tag_in         in   TAG_W  destination tag
//   out_valid_out  out  1      result present
//   out_ready_in   in   1      consumer takes result
//   data_out       out  XLEN   result
//   tag_out        out  TAG_W  tag of result
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  flush_in,
    input  logic                  in_valid_in,
    output logic                  in_ready_out,
    input  logic [XLEN-1:0]       rval1_in,
    input  logic [XLEN-1:0]       rval2_in,
    input  logic [ALU_FUNC_W-1:0] aluFunc_in,
    input  logic [TAG_W-1:0]      tag_in,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic [XLEN-1:0]       data_out,
    output logic [TAG_W-1:0]      tag_out
);

    logic [XLEN-1:0] alu_result;

    logic [PIPE_STAGES-1:0]            valid_reg;
    logic [PIPE_STAGES-1:0]            valid_next;
    logic [PIPE_STAGES-1:0][TAG_W-1:0] tag_reg;
    logic [PIPE_STAGES-1:0][XLEN-1:0]  data_reg;

    // Per-stage source (what the previous stage or the input offers).
    logic [PIPE_STAGES-1:0]            src_valid;
    logic [PIPE_STAGES-1:0][TAG_W-1:0] src_tag;
    logic [PIPE_STAGES-1:0][XLEN-1:0]  src_data;

    logic [PIPE_STAGES-1:0] stage_load;   // stage takes new contents this edge
    logic [PIPE_STAGES-1:0] payload_load; // stage captures a real op

    alu_core #(
        .XLEN (XLEN)
    ) u_alu_core (
        .a      (rval1_in),
        .b      (rval2_in),
        .func   (aluFunc_in),
        .result (alu_result)
    );

    // A stage can load if it is empty or its successor loads this cycle.
    // Walk from the output backwards so the chain stays within one process.
    always_comb begin
        logic next_load;
        next_load  = out_ready_in;
        stage_load = '0;
        for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
            stage_load[i] = !valid_reg[i] || next_load;
            next_load     = stage_load[i];
        end
    end

    // Depends only on out_ready_in and valid bits, never on in_valid_in.
    assign in_ready_out = stage_load[0];

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_src_in
                assign src_valid[gi] = in_valid_in;
                assign src_tag[gi]   = tag_in;
                assign src_data[gi]  = alu_result;
            end else begin : g_src_prev
                assign src_valid[gi] = valid_reg[gi-1];
                assign src_tag[gi]   = tag_reg[gi-1];
                assign src_data[gi]  = data_reg[gi-1];
            end

            // Flush wins over both accept and advance.
            assign valid_next[gi]   = flush_in ? 1'b0
                                    : (stage_load[gi] ? src_valid[gi] : valid_reg[gi]);
            assign payload_load[gi] = stage_load[gi] && src_valid[gi];
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_reg <= '0;
            tag_reg   <= '0;
            data_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                if (payload_load[i]) begin
                    tag_reg[i]  <= src_tag[i];
                    data_reg[i] <= src_data[i];
                end
            end
        end
    end

    assign out_valid_out = valid_reg[PIPE_STAGES-1];
    assign data_out      = data_reg[PIPE_STAGES-1];
    assign tag_out       = tag_reg[PIPE_STAGES-1];

endmodule
